// File: rtl/bldc_direction_sequencer.sv
// bldc_direction_sequencer: sequences the commutation-table direction with dead time, timed reversal brake and fault latching
module bldc_direction_sequencer #(
   parameter int DEADTIME_CYCLES = 64,
   parameter int BRAKE_CYCLES    = 100000,
   parameter int FAULT_LIMIT     = 3,
   parameter int STALL_CYCLES    = 2000000,
   parameter int CNT_W           = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] dir_req,
   input  logic [2:0] hall_values,
   input  logic       table_error,
   input  logic       fault_clear,
   output logic [2:0] dir_out,
   output logic       busy,
   output logic       fault,
   output logic [1:0] fault_code
);
   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_CW    = 3'd1;
   localparam logic [2:0] DIR_CCW   = 3'd2;
   localparam logic [2:0] DIR_BRAKE = 3'd3;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DEAD  = 3'd1;
   localparam logic [2:0] S_BRAKE = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;
   localparam int ERR_W = $clog2(FAULT_LIMIT + 1);
   localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYCLES - 1);
   localparam logic [CNT_W-1:0] BR_LAST = CNT_W'(BRAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STALL_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(FAULT_LIMIT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(FAULT_LIMIT);

   logic [2:0]       state_q, state_d;
   logic [2:0]       target_q, target_d;
   logic             rev_q, rev_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [2:0]       hall_q;
   logic [2:0]       dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             fault_q, fault_d;
   logic [1:0]       code_q, code_d;
   logic [2:0]       req;
   logic             hall_moved, err_trip, stall_trip;

   // next-state, timer, error counter and registered-output decode
   always_comb begin
      req = (dir_req == DIR_CW || dir_req == DIR_CCW || dir_req == DIR_BRAKE) ? dir_req : DIR_NONE;
      hall_moved = hall_values != hall_q;
      err_trip = state_q == S_RUN && table_error && err_q >= ERR_LAST;
      stall_trip = state_q == S_RUN && !hall_moved && timer_q >= ST_LAST;
      state_d = state_q;
      target_d = target_q;
      rev_d = rev_q;
      if (!enable && state_q != S_FAULT)
         state_d = S_IDLE;
      else if (err_trip || stall_trip)
         state_d = S_FAULT;
      else
         case (state_q)
            S_IDLE:
               if (req != DIR_NONE) begin
                  target_d = req;
                  rev_d = 1'b0;
                  state_d = S_DEAD;
               end
            S_DEAD:
               if (timer_q >= DT_LAST)
                  state_d = rev_q ? S_BRAKE : target_q == DIR_BRAKE ? S_HOLD : target_q == DIR_NONE ? S_IDLE : S_RUN;
            S_BRAKE:
               if (timer_q >= BR_LAST) begin
                  rev_d = 1'b0;
                  state_d = S_DEAD;
               end
            S_RUN:
               if (req != target_q) begin
                  target_d = req;
                  rev_d = req == DIR_CW || req == DIR_CCW;
                  state_d = S_DEAD;
               end
            S_HOLD:
               if (req == DIR_NONE)
                  state_d = S_IDLE;
               else if (req != DIR_BRAKE) begin
                  target_d = req;
                  state_d = S_DEAD;
               end
            S_FAULT:
               if (fault_clear && !enable)
                  state_d = S_IDLE;
            default:
               state_d = S_IDLE;
         endcase
      timer_d = (state_d != state_q || (state_q == S_RUN && hall_moved)) ? '0 : timer_q + 1'b1;
      err_d = (state_q == S_RUN && state_d == S_RUN && table_error) ? (err_q == ERR_MAX ? err_q : err_q + 1'b1) : '0;
      code_d = state_d != S_FAULT ? 2'd0 : state_q != S_FAULT ? (err_trip ? 2'd1 : 2'd2) : code_q;
      dir_d = state_d == S_RUN ? target_d : (state_d == S_BRAKE || state_d == S_HOLD) ? DIR_BRAKE : DIR_NONE;
      busy_d = state_d == S_DEAD || state_d == S_BRAKE;
      fault_d = state_d == S_FAULT;
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         target_q <= DIR_NONE;
         rev_q <= 1'b0;
         timer_q <= '0;
         err_q <= '0;
         hall_q <= '0;
         dir_q <= DIR_NONE;
         busy_q <= 1'b0;
         fault_q <= 1'b0;
         code_q <= 2'd0;
      end else begin
         state_q <= state_d;
         target_q <= target_d;
         rev_q <= rev_d;
         timer_q <= timer_d;
         err_q <= err_d;
         hall_q <= hall_values;
         dir_q <= dir_d;
         busy_q <= busy_d;
         fault_q <= fault_d;
         code_q <= code_d;
      end
   end

   assign dir_out = dir_q;
   assign busy = busy_q;
   assign fault = fault_q;
   assign fault_code = code_q;
endmodule
